// File: rtl/spi_ioexp_v2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_ioexp_pkg
// Purpose  : Shared types and helpers for the SPI I/O expander: FSM state
//            encoding and SPI-mode edge selection.
// Ports    : none (package)
// Revision : 2.0 - second-generation expander
// ============================================================================
package spi_ioexp_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  typedef enum logic [0:0] {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } edge_t;

  // Leading edge leaves the idle level: rising when CPOL=0, falling when CPOL=1.
  // CPHA=0 samples on the leading edge, CPHA=1 on the trailing edge.
  function automatic edge_t sample_edge(input logic cpol, input logic cpha);
    edge_t lead;
    edge_t trail;
    lead  = cpol ? EDGE_FALL : EDGE_RISE;
    trail = cpol ? EDGE_RISE : EDGE_FALL;
    return cpha ? trail : lead;
  endfunction

  function automatic edge_t change_edge(input logic cpol, input logic cpha);
    return (sample_edge(cpol, cpha) == EDGE_RISE) ? EDGE_FALL : EDGE_RISE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_ioexp_v2_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_ioexp_v2_if
// Purpose  : SPI pin bundle between an SPI master and the I/O expander.
// Ports    : sclk, ce_n, sin driven by the master; sout driven by the slave.
// Revision : 2.0 - second-generation expander
// ============================================================================
interface spi_ioexp_v2_if;
  logic sclk;
  logic ce_n;
  logic sin;
  logic sout;

  modport master (output sclk, output ce_n, output sin, input sout);
  modport slave  (input sclk, input ce_n, input sin, output sout);
endinterface
`default_nettype wire

// File: rtl/spi_ioexp_v2_sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_det
// Purpose  : Synchronises an asynchronous level into clk and produces
//            single-cycle rise/fall pulses from the synchronised value.
// Ports    : clk, reset (async, active high), d (async in),
//            rise, fall (1-cycle pulses)
// Revision : 2.0 - second-generation expander
// ============================================================================
module sync_edge_det #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic d,
  output logic      rise,
  output logic      fall
);
  import spi_ioexp_pkg::*;

  logic [STAGES-1:0] r_sync;
  logic              r_last;
  logic              w_q;

  // Preset to the idle level so reset release never looks like an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_last <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
      r_last <= r_sync[STAGES-1];
    end
  end

  assign w_q  = r_sync[STAGES-1];
  assign rise = w_q & ~r_last;
  assign fall = ~w_q & r_last;
endmodule
`default_nettype wire

// File: rtl/spi_ioexp_v2.sv
`default_nettype none
// ============================================================================
// Module   : spi_ioexp_v2
// Purpose  : SPI-slave I/O expander. A frame on sin loads OUTBITS parallel
//            outputs; INBITS parallel inputs are shifted out on sout in the
//            same frame. All SPI pins are oversampled in the clk domain.
// Ports    : clk, reset (async, active high)
//            spi       - SPI pins (slave modport: sclk, ce_n, sin, sout)
//            inputs    - parallel inputs, snapshotted at frame start
//            outputs   - parallel outputs, updated on a valid frame end
//            irq       - synced inputs differ from last snapshot (sticky)
//            frame_err - 1-cycle pulse when a frame length != OUTBITS
// Revision : 2.0 - modes, bit order, frame checking, input-change irq
// ============================================================================
module spi_ioexp_v2 #(
  parameter int INBITS      = 3,
  parameter int OUTBITS     = 7,
  parameter int SYNC_STAGES = 2,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int LSB_FIRST   = 1
) (
  input  wire logic         clk,
  input  wire logic         reset,
  spi_ioexp_v2_if.slave     spi,
  input  wire logic [INBITS-1:0]  inputs,
  output logic [OUTBITS-1:0]      outputs,
  output logic                    irq,
  output logic                    frame_err
);
  import spi_ioexp_pkg::*;

  localparam int                 c_CNT_W   = $clog2(OUTBITS + 2);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(OUTBITS + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_OK  = c_CNT_W'(OUTBITS);
  localparam edge_t              c_SAMPLE  = sample_edge(CPOL != 0, CPHA != 0);
  localparam edge_t              c_CHANGE  = change_edge(CPOL != 0, CPHA != 0);
  localparam bit                 c_CPHA1   = (CPHA != 0);

  // ---------------------------------------------------------------- sync
  logic w_sclk_rise, w_sclk_fall, w_ce_rise, w_ce_fall;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL != 0)) u_sclk_sync (
    .clk(clk), .reset(reset), .d(spi.sclk), .rise(w_sclk_rise), .fall(w_sclk_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ce_sync (
    .clk(clk), .reset(reset), .d(spi.ce_n), .rise(w_ce_rise), .fall(w_ce_fall)
  );

  logic [SYNC_STAGES-1:0] r_sin_sync;
  logic [INBITS-1:0]      r_in_sync [SYNC_STAGES];
  logic                   w_sin;
  logic [INBITS-1:0]      w_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sin_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) r_in_sync[i] <= '0;
    end else begin
      r_sin_sync   <= {r_sin_sync[SYNC_STAGES-2:0], spi.sin};
      r_in_sync[0] <= inputs;
      for (int i = 1; i < SYNC_STAGES; i++) r_in_sync[i] <= r_in_sync[i-1];
    end
  end

  assign w_sin = r_sin_sync[SYNC_STAGES-1];
  assign w_in  = r_in_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------- FSM
  state_t r_state, w_state_nxt;
  logic   w_start, w_end, w_sample, w_change;
  logic   w_sclk_sample, w_sclk_change;

  assign w_sclk_sample = (c_SAMPLE == EDGE_RISE) ? w_sclk_rise : w_sclk_fall;
  assign w_sclk_change = (c_CHANGE == EDGE_RISE) ? w_sclk_rise : w_sclk_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // A chip-enable edge in the same cycle as an sclk edge discards the sclk edge.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_end       = 1'b0;
    w_sample    = 1'b0;
    w_change    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ce_fall) begin
          w_start     = 1'b1;
          w_state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (w_ce_rise) begin
          w_end       = 1'b1;
          w_state_nxt = IDLE;
        end else if (!w_ce_fall) begin
          w_sample = w_sclk_sample;
          w_change = w_sclk_change;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  logic [OUTBITS-1:0] r_shift_in, r_outputs;
  logic [INBITS-1:0]  r_shift_out, r_snapshot;
  logic [c_CNT_W-1:0] r_bit_cnt;
  logic               r_first, r_frame_err, r_irq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift_in  <= '0;
      r_outputs   <= '0;
      r_shift_out <= '0;
      r_snapshot  <= '0;
      r_bit_cnt   <= '0;
      r_first     <= 1'b0;
      r_frame_err <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;

      if (w_start) begin
        r_shift_out <= w_in;
        r_snapshot  <= w_in;
        r_bit_cnt   <= '0;
        r_first     <= 1'b1;
      end

      if (w_sample) begin
        if (LSB_FIRST != 0) r_shift_in <= {w_sin, r_shift_in[OUTBITS-1:1]};
        else                r_shift_in <= {r_shift_in[OUTBITS-2:0], w_sin};
        // Saturating one past OUTBITS keeps over-long frames distinguishable.
        if (r_bit_cnt != c_CNT_MAX) r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      if (w_change) begin
        // With CPHA=1 the first leading edge only announces bit 0, already on sout.
        if (c_CPHA1 && r_first)  r_first     <= 1'b0;
        else if (LSB_FIRST != 0) r_shift_out <= r_shift_out >> 1;
        else                     r_shift_out <= r_shift_out << 1;
      end

      if (w_end) begin
        if (r_bit_cnt == c_CNT_OK) r_outputs   <= r_shift_in;
        else                       r_frame_err <= 1'b1;
      end

      if (w_start)                r_irq <= 1'b0;
      else if (w_in != r_snapshot) r_irq <= 1'b1;
    end
  end

  assign spi.sout  = (r_state == ACTIVE) &&
                     ((LSB_FIRST != 0) ? r_shift_out[0] : r_shift_out[INBITS-1]);
  assign outputs   = r_outputs;
  assign irq       = r_irq;
  assign frame_err = r_frame_err;
endmodule
`default_nettype wire

// File: tb/tb_spi_ioexp_v2.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_ioexp_v2
// Purpose  : Self-checking bench for spi_ioexp_v2. Eight instances cover all
//            four SPI modes in both bit orders (index g: bit0=CPHA, bit1=CPOL,
//            g>=4 means MSB first).
// Revision : 2.0
// ============================================================================
module tb_spi_ioexp_v2;
  localparam int HALF = 4;   // sclk half period in clk cycles

  logic       clk;
  logic       reset;
  logic [2:0] inputs;
  logic [7:0] sclk_a, cen_a, sin_a;
  wire  [7:0] sout_a;
  wire  [7:0] irq_a, ferr_a;
  wire  [6:0] outs [8];

  int n_assert = 0;
  int n_fail   = 0;
  int ferr_cnt [8];
  logic [6:0] model_out [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 8; g++) begin : g_dut
    localparam int P_CPOL = (g / 2) % 2;
    localparam int P_CPHA = g % 2;
    localparam int P_LSB  = (g < 4) ? 1 : 0;
    spi_ioexp_v2_if bus ();
    assign bus.sclk  = sclk_a[g];
    assign bus.ce_n  = cen_a[g];
    assign bus.sin   = sin_a[g];
    assign sout_a[g] = bus.sout;
    spi_ioexp_v2 #(
      .INBITS(3), .OUTBITS(7), .SYNC_STAGES(2),
      .CPOL(P_CPOL), .CPHA(P_CPHA), .LSB_FIRST(P_LSB)
    ) u_dut (
      .clk(clk), .reset(reset), .spi(bus), .inputs(inputs),
      .outputs(outs[g]), .irq(irq_a[g]), .frame_err(ferr_a[g])
    );
  end

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) if (ferr_a[i] === 1'b1) ferr_cnt[i] <= ferr_cnt[i] + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic cpol_of(input int g); return logic'((g / 2) % 2); endfunction
  function automatic logic cpha_of(input int g); return logic'(g % 2);       endfunction
  function automatic bit   lsb_of(input int g);  return g < 4;               endfunction

  // Bit i of the frame as seen on the wire.
  function automatic logic tx_bit(input int g, input logic [6:0] d, input int i);
    return lsb_of(g) ? d[i] : d[6-i];
  endfunction

  // Reference sout stream: the three inputs in wire order, then zeros.
  function automatic logic [8:0] model_sout(input int g, input logic [2:0] inp);
    logic [8:0] s;
    s = '0;
    for (int i = 0; i < 3; i++) s[i] = lsb_of(g) ? inp[i] : inp[2-i];
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ce_start(input int g);
    cen_a[g] = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic send_bit(input int g, input logic b, output logic s);
    if (!cpha_of(g)) begin
      sin_a[g] = b;
      wait_clk(HALF);
      s = sout_a[g];
      sclk_a[g] = ~cpol_of(g);
      wait_clk(HALF);
      sclk_a[g] = cpol_of(g);
    end else begin
      sclk_a[g] = ~cpol_of(g);
      sin_a[g]  = b;
      wait_clk(HALF);
      s = sout_a[g];
      sclk_a[g] = cpol_of(g);
      wait_clk(HALF);
    end
  endtask

  task automatic ce_end(input int g);
    wait_clk(HALF);
    cen_a[g] = 1'b1;
    wait_clk(8);
  endtask

  task automatic do_frame(input int g, input logic [6:0] d, input logic [2:0] inp,
                          input int nbits, output logic [8:0] sq);
    logic b, s;
    inputs = inp;
    wait_clk(6);
    ce_start(g);
    sq = '0;
    for (int i = 0; i < nbits; i++) begin
      b = (i < 7) ? tx_bit(g, d, i) : logic'($urandom_range(0, 1));
      send_bit(g, b, s);
      sq[i] = s;
    end
    ce_end(g);
  endtask

  task automatic check_frame(input string name, input int g, input int nbits,
                             input logic [8:0] sq, input logic [8:0] exp_sq,
                             input logic [6:0] exp_o, input int exp_err, input int ferr0);
    logic [8:0] mask;
    mask = 9'((1 << nbits) - 1);
    check($sformatf("%s_outputs", name), 32'(outs[g]), 32'(exp_o));
    check($sformatf("%s_frame_err", name), 32'(ferr_cnt[g] - ferr0), 32'(exp_err));
    check($sformatf("%s_sout", name), 32'(sq & mask), 32'(exp_sq & mask));
    check($sformatf("%s_irq", name), 32'(irq_a[g]), 32'd0);
  endtask

  typedef struct {
    int         g;
    logic [6:0] data;
    logic [2:0] inp;
    int         nbits;
    logic [6:0] exp_o;
    int         exp_err;
    logic [8:0] exp_sq;
  } vec_t;

  initial begin
    vec_t       vecs [12];
    logic [8:0] sq;
    logic [6:0] d;
    logic [2:0] inp;
    logic       s;
    int         g, nb, f0, k;

    vecs[0]  = '{0, 7'h5A, 3'b101, 7, 7'h5A, 0, 9'h005};
    vecs[1]  = '{0, 7'h00, 3'b101, 6, 7'h5A, 1, 9'h005};
    vecs[2]  = '{0, 7'h7F, 3'b101, 9, 7'h5A, 1, 9'h005};
    vecs[3]  = '{0, 7'h5A, 3'b110, 7, 7'h5A, 0, 9'h006};
    vecs[4]  = '{1, 7'h5A, 3'b101, 7, 7'h5A, 0, 9'h005};
    vecs[5]  = '{2, 7'h5A, 3'b101, 7, 7'h5A, 0, 9'h005};
    vecs[6]  = '{3, 7'h5A, 3'b101, 7, 7'h5A, 0, 9'h005};
    vecs[7]  = '{4, 7'h33, 3'b101, 7, 7'h33, 0, 9'h005};
    vecs[8]  = '{4, 7'h33, 3'b110, 7, 7'h33, 0, 9'h003};
    vecs[9]  = '{5, 7'h33, 3'b101, 7, 7'h33, 0, 9'h005};
    vecs[10] = '{6, 7'h33, 3'b101, 7, 7'h33, 0, 9'h005};
    vecs[11] = '{7, 7'h33, 3'b101, 7, 7'h33, 0, 9'h005};

    reset  = 1'b1;
    inputs = 3'b000;
    for (int i = 0; i < 8; i++) begin
      sclk_a[i]    = cpol_of(i);
      cen_a[i]     = 1'b1;
      sin_a[i]     = 1'b0;
      ferr_cnt[i]  = 0;
      model_out[i] = '0;
    end
    wait_clk(5);
    reset = 1'b0;
    wait_clk(5);

    // Reset state
    for (int i = 0; i < 8; i++) check($sformatf("reset_outputs%0d", i), 32'(outs[i]), 32'd0);
    check("reset_sout", 32'(sout_a), 32'd0);
    check("reset_irq", 32'(irq_a), 32'd0);
    check("reset_ferr", 32'(ferr_cnt[0] + ferr_cnt[7]), 32'd0);

    // Directed table
    for (int v = 0; v < 12; v++) begin
      f0 = ferr_cnt[vecs[v].g];
      do_frame(vecs[v].g, vecs[v].data, vecs[v].inp, vecs[v].nbits, sq);
      check_frame($sformatf("vec%0d", v), vecs[v].g, vecs[v].nbits, sq, vecs[v].exp_sq,
                  vecs[v].exp_o, vecs[v].exp_err, f0);
      model_out[vecs[v].g] = vecs[v].exp_o;
    end

    // Input-change interrupt while idle
    f0 = ferr_cnt[0];
    do_frame(0, 7'h5A, 3'b000, 7, sq);
    check("irq_idle_clear", 32'(irq_a[0]), 32'd0);
    inputs = 3'b010;
    k = 0;
    while (irq_a[0] !== 1'b1 && k < 3) begin
      @(posedge clk); #1;
      k++;
    end
    check("irq_set", 32'(irq_a[0]), 32'd1);
    cen_a[0] = 1'b0;
    wait_clk(HALF);
    check("irq_clear_on_ce_fall", 32'(irq_a[0]), 32'd0);
    for (int i = 0; i < 7; i++) send_bit(0, tx_bit(0, 7'h2C, i), s);
    ce_end(0);
    model_out[0] = 7'h2C;
    check("irq_frame_outputs", 32'(outs[0]), 32'(model_out[0]));

    // ce_n rise in the same clk as the sample edge: that edge is dropped
    f0 = ferr_cnt[0];
    ce_start(0);
    for (int i = 0; i < 7; i++) send_bit(0, tx_bit(0, 7'h4B, i), s);
    sin_a[0] = 1'b1;
    wait_clk(HALF);
    sclk_a[0] = 1'b1;
    cen_a[0]  = 1'b1;
    wait_clk(8);
    sclk_a[0] = 1'b0;
    wait_clk(8);
    model_out[0] = 7'h4B;
    check("simul_outputs", 32'(outs[0]), 32'(model_out[0]));
    check("simul_frame_err", 32'(ferr_cnt[0] - f0), 32'd0);

    // Reset mid-frame
    f0 = ferr_cnt[0];
    inputs = 3'b111;
    wait_clk(6);
    ce_start(0);
    for (int i = 0; i < 3; i++) send_bit(0, tx_bit(0, 7'h11, i), s);
    reset = 1'b1;
    #1;
    check("midreset_outputs", 32'(outs[0]), 32'd0);
    check("midreset_sout", 32'(sout_a[0]), 32'd0);
    wait_clk(2);
    cen_a[0] = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 8; i++) model_out[i] = '0;
    check("midreset_no_ferr", 32'(ferr_cnt[0] - f0), 32'd0);
    f0 = ferr_cnt[0];
    do_frame(0, 7'h11, 3'b001, 7, sq);
    model_out[0] = 7'h11;
    check_frame("after_reset", 0, 7, sq, model_sout(0, 3'b001), model_out[0], 0, f0);

    // Randomised frames against the reference model
    for (int r = 0; r < 40; r++) begin
      g   = int'($urandom_range(0, 7));
      d   = 7'($urandom);
      inp = 3'($urandom);
      case ($urandom_range(0, 9))
        0:       nb = 6;
        1:       nb = 8;
        2:       nb = 9;
        default: nb = 7;
      endcase
      f0 = ferr_cnt[g];
      do_frame(g, d, inp, nb, sq);
      if (nb == 7) model_out[g] = d;
      check_frame($sformatf("rand%0d_g%0d_n%0d", r, g, nb), g, nb, sq, model_sout(g, inp),
                  model_out[g], (nb == 7) ? 0 : 1, f0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
